mul_seq_unit: RTL and testbench
===============================

MUL_SEQ_UNIT -- requirements
Module: mul_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; SHALL be 8 or greater and a power of 2.
REQ-002 Parameter BITS_PER_CYCLE, default 1: multiplier bits consumed per CALC cycle; SHALL be a power of 2 that divides WIDTH.
REQ-003 Parameter EARLY_OUT, default 1: 1 enables early termination of CALC.
REQ-004 Parameter CACHE_EN, default 1: 1 enables the last-result cache.
REQ-005 clk input 1: clock; all state SHALL update on the rising edge.
REQ-006 resetn input 1: reset, synchronous, active-low.
REQ-007 factor1 input WIDTH: multiplicand.
REQ-008 factor2 input WIDTH: multiplier.
REQ-009 mul_op input 2: operation select. 0=MUL (low half), 1=MULH (signed x signed), 2=MULHSU (signed factor1 x unsigned factor2), 3=MULHU (unsigned x unsigned). Ops 1-3 return the high half.
REQ-010 valid input 1: request strobe; held high by the requester with stable operands until ready.
REQ-011 ready output 1: one-cycle completion pulse.
REQ-012 product output WIDTH: result.
REQ-013 busy output 1: high while in CALC or FIX.

Function
REQ-014 States SHALL be one-hot: IDLE, CALC, FIX.
REQ-015 IDLE, valid=1 and ready=0: the block SHALL accept the request. It latches the absolute values of the operands (negate only if the operand is signed for mul_op and its MSB is 1), latches sign_neg = (f1 signed & f1 MSB) XOR (f2 signed & f2 MSB), clears the 2*WIDTH accumulator, and goes to CALC, unless a cache hit occurs (REQ-021).
REQ-016 IDLE, valid=1 and ready=1: the block SHALL NOT accept; ready SHALL clear on that edge.
REQ-017 CALC: each cycle the block SHALL add (multiplicand_abs * low BITS_PER_CYCLE bits of the multiplier register), shifted left by the current bit offset, into the accumulator. It then shifts the multiplier register right by BITS_PER_CYCLE and advances the offset.
REQ-018 CALC SHALL exit to FIX after WIDTH/BITS_PER_CYCLE cycles. With EARLY_OUT=1 it SHALL also exit once the post-shift multiplier register is zero. At least one CALC cycle always executes.
REQ-019 FIX: the block SHALL two's-complement negate the 2*WIDTH accumulator if sign_neg=1, set ready=1, update the cache when CACHE_EN=1, and go to IDLE.
REQ-020 Latency, EARLY_OUT=0: ready SHALL be high in the cycle after the (WIDTH/BITS_PER_CYCLE + 1)th edge following the accept edge, i.e. 33 edges for 32/1 and 9 edges for 32/4.
REQ-021 Cache, CACHE_EN=1: the cache holds the last full signed/unsigned 2*WIDTH product, tagged with factor1, factor2, f1_signed, f2_signed and a valid bit. A hit on acceptance SHALL set ready=1 on the accept edge, leave the state in IDLE, and source product from the cache.
REQ-022 Hit condition: cache valid, factor1 and factor2 equal to the tags, and either matching signedness flags or mul_op=MUL, which hits regardless of signedness.
REQ-023 product SHALL be the accumulator bits [WIDTH-1:0] for MUL and bits [2*WIDTH-1:WIDTH] otherwise.
REQ-024 product SHALL be held stable from the ready pulse until the next accept edge.
REQ-025 Changes on valid or operand inputs during CALC or FIX SHALL be ignored.
REQ-026 All arithmetic is modulo 2^(2*WIDTH); the most-negative operand SHALL produce the correct result (e.g. MULH 0x80000000 x 0x80000000 = 0x40000000).

Reset
REQ-027 resetn=0 at any clock edge, including mid-CALC or FIX, SHALL force state=IDLE, ready=0, busy=0, accumulator=0 (product=0), and cache valid=0.
REQ-028 The first request after reset SHALL always take the CALC path.

Verification
REQ-029 WIDTH=32, BPC=1, EARLY_OUT=0, MUL 7 x 6 -> ready after 33 edges, product=42, ready high exactly one cycle.
REQ-030 MULH 0xFFFFFFFF x 0xFFFFFFFF -> product=0x00000000. Then MULHU with the same operands -> CALC path (tag miss), product=0xFFFFFFFE.
REQ-031 MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF. Then MUL with the same operands -> cache hit, ready on the edge after accept, product=0xFFFFFFFE.
REQ-032 EARLY_OUT=1, MUL 0x12345678 x 3 -> exactly 2 CALC cycles, then FIX; product=0x369D0368.
REQ-033 BPC=4, MULH 0x80000000 x 0x80000000 -> ready 9 edges after accept, product=0x40000000.
REQ-034 resetn low during the 10th CALC cycle -> next cycle ready=0, busy=0, product=0. A repeat of the same request takes the full CALC latency.

Source files
------------

// File: rtl/mul_seq_unit.sv
// mul_seq_unit
//   Sequential shift-add multiplier, RISC-V M style (MUL/MULH/MULHSU/MULHU).
//   Operands are reduced to magnitudes on acceptance and multiplied
//   BITS_PER_CYCLE multiplier bits at a time. The sign is applied in FIX.
//   An optional single-entry cache returns a repeated request in the accept cycle.
//
// Ports
//   clk      in   clock, rising edge
//   resetn   in   synchronous, active-low reset
//   factor1  in   multiplicand            [WIDTH]
//   factor2  in   multiplier              [WIDTH]
//   mul_op   in   0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
//   valid    in   request, held with stable operands until ready
//   ready    out  one-cycle completion pulse
//   product  out  low half (MUL) or high half (others)   [WIDTH]
//   busy     out  high while in CALC or FIX
module mul_seq_unit #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned EARLY_OUT      = 1,
    parameter int unsigned CACHE_EN       = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] factor1,
    input  logic [WIDTH-1:0] factor2,
    input  logic [1:0]       mul_op,
    input  logic             valid,
    output logic             ready,
    output logic [WIDTH-1:0] product,
    output logic             busy
);

    localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW    = $clog2(STEPS) + 1;
    localparam int unsigned OW    = $clog2(2 * WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_CALC = 3'b010,
        S_FIX  = 3'b100
    } state_t;

    state_t r_state, w_state_next;

    logic [WIDTH-1:0]   r_mcand, r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [OW-1:0]      r_offset;
    logic [CW-1:0]      r_cnt;
    logic               r_sign_neg, r_ready, r_op_mul;
    logic [WIDTH-1:0]   r_f1, r_f2;
    logic               r_s1, r_s2;

    logic               r_c_valid, r_c_s1, r_c_s2;
    logic [WIDTH-1:0]   r_c_f1, r_c_f2;
    logic [2*WIDTH-1:0] r_c_prod;

    logic               w_f1_signed, w_f2_signed, w_f1_neg, w_f2_neg;
    logic [WIDTH-1:0]   w_f1_abs, w_f2_abs, w_mplier_next;
    logic [BITS_PER_CYCLE-1:0] w_digit;
    logic [2*WIDTH-1:0] w_pp, w_fixed;
    logic               w_accept, w_hit, w_last;

    always_comb begin
        w_f1_signed   = (mul_op == 2'd1) || (mul_op == 2'd2);
        w_f2_signed   = (mul_op == 2'd1);
        w_f1_neg      = w_f1_signed & factor1[WIDTH-1];
        w_f2_neg      = w_f2_signed & factor2[WIDTH-1];
        // The most-negative value negates to itself, which is its correct magnitude as unsigned.
        w_f1_abs      = w_f1_neg ? (~factor1 + 1'b1) : factor1;
        w_f2_abs      = w_f2_neg ? (~factor2 + 1'b1) : factor2;

        w_accept      = (r_state == S_IDLE) && valid && !r_ready;
        // MUL only uses the low half, which is identical for any signedness.
        w_hit         = (CACHE_EN != 0) && r_c_valid &&
                        (factor1 == r_c_f1) && (factor2 == r_c_f2) &&
                        ((mul_op == 2'd0) ||
                         ((w_f1_signed == r_c_s1) && (w_f2_signed == r_c_s2)));

        w_digit       = r_mplier[BITS_PER_CYCLE-1:0];
        w_pp          = '0;
        for (int unsigned b = 0; b < BITS_PER_CYCLE; b++) begin
            if (w_digit[b]) begin
                w_pp = w_pp + ({{WIDTH{1'b0}}, r_mcand} << b);
            end
        end
        w_pp          = w_pp << r_offset;
        w_mplier_next = r_mplier >> BITS_PER_CYCLE;
        w_last        = (r_cnt == CW'(STEPS - 1)) ||
                        ((EARLY_OUT != 0) && (w_mplier_next == '0));
        w_fixed       = r_sign_neg ? (~r_acc + 1'b1) : r_acc;

        w_state_next  = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_hit) w_state_next = S_CALC;
            S_CALC:  if (w_last) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_offset   <= '0;
            r_cnt      <= '0;
            r_sign_neg <= 1'b0;
            r_ready    <= 1'b0;
            r_op_mul   <= 1'b0;
            r_f1       <= '0;
            r_f2       <= '0;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_c_valid  <= 1'b0;
            r_c_f1     <= '0;
            r_c_f2     <= '0;
            r_c_s1     <= 1'b0;
            r_c_s2     <= 1'b0;
            r_c_prod   <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_mul <= (mul_op == 2'd0);
                        r_f1     <= factor1;
                        r_f2     <= factor2;
                        r_s1     <= w_f1_signed;
                        r_s2     <= w_f2_signed;
                        if (w_hit) begin
                            r_acc   <= r_c_prod;
                            r_ready <= 1'b1;
                        end else begin
                            r_mcand    <= w_f1_abs;
                            r_mplier   <= w_f2_abs;
                            r_sign_neg <= w_f1_neg ^ w_f2_neg;
                            r_acc      <= '0;
                            r_offset   <= '0;
                            r_cnt      <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r_acc    <= r_acc + w_pp;
                    r_mplier <= w_mplier_next;
                    r_offset <= r_offset + OW'(BITS_PER_CYCLE);
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_acc   <= w_fixed;
                    r_ready <= 1'b1;
                    if (CACHE_EN != 0) begin
                        r_c_valid <= 1'b1;
                        r_c_f1    <= r_f1;
                        r_c_f2    <= r_f2;
                        r_c_s1    <= r_s1;
                        r_c_s2    <= r_s2;
                        r_c_prod  <= w_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready   = r_ready;
    assign busy    = (r_state == S_CALC) || (r_state == S_FIX);
    assign product = r_op_mul ? r_acc[WIDTH-1:0] : r_acc[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_seq_unit.sv
// tb_mul_seq_unit
//   Directed bench for three mul_seq_unit configurations:
//     d0: 32/1, no early-out, cache   d1: 32/1, early-out, cache   d2: 32/4, no early-out, cache
//   Latency is counted in clock edges including the accept edge.
`timescale 1ns/1ps
module tb_mul_seq_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] f1  [3];
    logic [31:0] f2  [3];
    logic [1:0]  op  [3];
    logic        vld [3];
    logic        rdy [3];
    logic        bsy [3];
    logic [31:0] prod[3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_seq_unit #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_OUT(0), .CACHE_EN(1)) u0 (
        .clk(clk), .resetn(resetn), .factor1(f1[0]), .factor2(f2[0]), .mul_op(op[0]),
        .valid(vld[0]), .ready(rdy[0]), .product(prod[0]), .busy(bsy[0]));
    mul_seq_unit #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1), .CACHE_EN(1)) u1 (
        .clk(clk), .resetn(resetn), .factor1(f1[1]), .factor2(f2[1]), .mul_op(op[1]),
        .valid(vld[1]), .ready(rdy[1]), .product(prod[1]), .busy(bsy[1]));
    mul_seq_unit #(.WIDTH(32), .BITS_PER_CYCLE(4), .EARLY_OUT(0), .CACHE_EN(1)) u2 (
        .clk(clk), .resetn(resetn), .factor1(f1[2]), .factor2(f2[2]), .mul_op(op[2]),
        .valid(vld[2]), .ready(rdy[2]), .product(prod[2]), .busy(bsy[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request, scrambles operands once accepted, and checks latency,
    // result, the one-cycle ready pulse and product hold while valid stays high.
    task automatic run(input int d, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_p, input int exp_edges, input string tag);
        int          n;
        bit          seen;
        logic [31:0] held;
        @(negedge clk);
        op[d] = o; f1[d] = a; f2[d] = b; vld[d] = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1 && exp_edges > 1) check({tag, " busy"}, 64'(bsy[d]), 64'd1);
            if (rdy[d]) seen = 1;
            else begin
                f1[d] = $urandom;
                f2[d] = $urandom;
            end
        end
        check({tag, " latency"}, 64'(n), 64'(exp_edges));
        check({tag, " product"}, 64'(prod[d]), 64'(exp_p));
        held = prod[d];
        @(posedge clk); #1;
        check({tag, " ready pulse"}, 64'(rdy[d]), 64'd0);
        check({tag, " no re-accept"}, 64'(bsy[d]), 64'd0);
        check({tag, " held"}, 64'(prod[d]), 64'(held));
        vld[d] = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f1[i] = '0; f2[i] = '0; op[i] = '0; vld[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset ready d%0d", i), 64'(rdy[i]), 64'd0);
            check($sformatf("reset busy d%0d", i), 64'(bsy[i]), 64'd0);
            check($sformatf("reset product d%0d", i), 64'(prod[i]), 64'd0);
        end
        @(negedge clk);
        resetn = 1'b1;

        run(0, 2'd0, 32'd7,        32'd6,        32'd42,       34, "d0 MUL 7x6");
        run(0, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, "d0 MULH -1x-1");
        run(0, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "d0 MULHU tag miss");
        run(0, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1,  "d0 MULHU hit");
        run(0, 2'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, "d0 MULHSU -1x2");
        run(0, 2'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1,  "d0 MUL hit");
        run(0, 2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, "d0 MULH minneg");
        run(0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34, "d0 MUL -1x-1");

        run(1, 2'd0, 32'h12345678, 32'd3,        32'h369D0368, 4,  "d1 MUL early-out");
        run(1, 2'd0, 32'd7,        32'd6,        32'd42,       5,  "d1 MUL 7x6");

        run(2, 2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 10, "d2 MULH minneg");
        run(2, 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 10, "d2 MULHSU");

        // Reset during the 10th CALC cycle of a fresh request on d0.
        @(negedge clk);
        op[0] = 2'd0; f1[0] = 32'h00001234; f2[0] = 32'h00000100; vld[0] = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        check("mid-CALC busy", 64'(bsy[0]), 64'd1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("abort ready", 64'(rdy[0]), 64'd0);
        check("abort busy", 64'(bsy[0]), 64'd0);
        check("abort product", 64'(prod[0]), 64'd0);
        vld[0] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run(0, 2'd0, 32'h00001234, 32'h00000100, 32'h00123400, 34, "d0 repeat after reset");
        run(0, 2'd0, 32'h00001234, 32'h00000100, 32'h00123400, 1,  "d0 repeat hit");

        // Cache was cleared by reset, so the first d1 request misses.
        run(1, 2'd0, 32'h12345678, 32'd3,        32'h369D0368, 4,  "d1 first after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
